display_scheduler: RTL and testbench

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

---
 rtl/display_scheduler.sv | 115 +++++++++++
 tb/tb_display_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// Clock/alarm display mode scheduler with edit blinking and alarm override.
// Optional: DISP_LEADING_ZERO_BLANK_EN darkens the leftmost digit below 10:00.
module display_scheduler #(
    parameter int TIMEOUT_MS    = 10000,
    parameter int BLINK_HALF_MS = 250
) (
    input  logic        CLOCK_1ms,
    input  logic        RESET,
    input  logic [11:0] CUR_TIME,
    input  logic [11:0] ALARM_TIME,
    input  logic        BTN_MODE,
    input  logic        BTN_ACT,
    input  logic        ALARM_RING,
    output logic [11:0] DISP_TIME,
    output logic [3:0]  BLANK_MASK,
    output logic [1:0]  MODE
);

    localparam int TW = $clog2(TIMEOUT_MS + 1);
    localparam int BW = $clog2(BLINK_HALF_MS + 1);

    localparam logic [1:0] SHOW_CLK = 2'b00;
    localparam logic [1:0] SHOW_ALM = 2'b01;
    localparam logic [1:0] EDIT_HR  = 2'b10;
    localparam logic [1:0] EDIT_MIN = 2'b11;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_MS - 1);
    localparam logic [TW-1:0] TMO_SAT  = TW'(TIMEOUT_MS);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_HALF_MS - 1);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [BW-1:0] blk_q, blk_d;
    logic          ph_q, ph_d;
    logic          ring_q;
    logic [11:0]   disp_q, disp_d;
    logic [3:0]    mask_q, mask_d;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        blk_d   = blk_q + BW'(1);
        ph_d    = ph_q;
        if (blk_q == BLK_LAST) begin
            blk_d = '0;
            ph_d  = ~ph_q;
        end
        // The ringing alarm freezes navigation; only the blinker keeps running.
        if (!ALARM_RING) begin
            if (BTN_MODE) begin
                state_d = 2'(state_q + 2'd1);
            end else if (state_q != SHOW_CLK && tmo_q == TMO_LAST) begin
                state_d = SHOW_CLK;
            end
            if (BTN_MODE || BTN_ACT || state_d != state_q) begin
                tmo_d = '0;
            end else if (state_q != SHOW_CLK && tmo_q != TMO_SAT) begin
                tmo_d = tmo_q + TW'(1);
            end
            // ring_q set here means the alarm just stopped: restart visible.
            if (BTN_ACT || state_d != state_q || ring_q) begin
                blk_d = '0;
                ph_d  = 1'b0;
            end
        end
    end

    always_comb begin
        disp_d = ALARM_TIME;
        if (ALARM_RING || state_d == SHOW_CLK) begin
            disp_d = CUR_TIME;
        end
        mask_d = 4'b0000;
        if (ALARM_RING) begin
            mask_d = {4{ph_d}};
        end else begin
            case (state_d)
                EDIT_HR:  mask_d = {ph_d, ph_d, 2'b00};
                EDIT_MIN: mask_d = {2'b00, ph_d, ph_d};
                default:  mask_d = 4'b0000;
            endcase
        end
`ifdef DISP_LEADING_ZERO_BLANK_EN
        if (disp_d < 12'd600) begin
            mask_d[3] = 1'b1;
        end
`else
`endif
    end

    always_ff @(posedge CLOCK_1ms) begin
        if (RESET) begin
            state_q <= SHOW_CLK;
            tmo_q   <= '0;
            blk_q   <= '0;
            ph_q    <= 1'b0;
            ring_q  <= 1'b0;
            disp_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            blk_q   <= blk_d;
            ph_q    <= ph_d;
            ring_q  <= ALARM_RING;
            disp_q  <= disp_d;
            mask_q  <= mask_d;
        end
    end

    assign DISP_TIME  = disp_q;
    assign BLANK_MASK = mask_q;
    assign MODE       = state_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed self-checking bench for display_scheduler.
module tb_display_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] cur = 12'd754;
    logic [11:0] alm = 12'd390;
    logic        bmode = 1'b0;
    logic        bact = 1'b0;
    logic        ring = 1'b0;
    logic [11:0] disp;
    logic [3:0]  mask;
    logic [1:0]  mode;

    int total = 0;
    int bad   = 0;

    display_scheduler dut (
        .CLOCK_1ms (clk),
        .RESET     (rst),
        .CUR_TIME  (cur),
        .ALARM_TIME(alm),
        .BTN_MODE  (bmode),
        .BTN_ACT   (bact),
        .ALARM_RING(ring),
        .DISP_TIME (disp),
        .BLANK_MASK(mask),
        .MODE      (mode)
    );

    always #5 clk = ~clk;

`ifdef DISP_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    function automatic logic [3:0] lz(input logic [11:0] v);
        return (LZ && v < 12'd600) ? 4'b1000 : 4'b0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_mode();
        bmode = 1'b1;
        step();
        bmode = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cur = 12'd754;
        step();
        step();
        total++;
        if (mode !== 2'b00) begin
            bad++;
            $display("FAIL rst_mode got %b want 00", mode);
        end
        total++;
        if (disp !== 12'd0) begin
            bad++;
            $display("FAIL rst_disp got %0d want 0", disp);
        end
        total++;
        if (mask !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mask got %b want 0000", mask);
        end
        rst = 1'b0;
        step();
        total++;
        if (disp !== 12'd754) begin
            bad++;
            $display("FAIL rel_disp got %0d want 754", disp);
        end
        total++;
        if (mode !== 2'b00) begin
            bad++;
            $display("FAIL rel_mode got %b want 00", mode);
        end
        total++;
        if (mask !== 4'b0000) begin
            bad++;
            $display("FAIL rel_mask got %b want 0000", mask);
        end
    endtask

    task automatic test_mode_cycle();
        logic [1:0]  em [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [11:0] ed [4] = '{12'd390, 12'd390, 12'd390, 12'd754};
        alm = 12'd390;
        for (int i = 0; i < 4; i++) begin
            pulse_mode();
            total++;
            if (mode !== em[i]) begin
                bad++;
                $display("FAIL cyc_mode%0d got %b want %b", i, mode, em[i]);
            end
            total++;
            if (disp !== ed[i]) begin
                bad++;
                $display("FAIL cyc_disp%0d got %0d want %0d", i, disp, ed[i]);
            end
            total++;
            if (mask !== lz(ed[i])) begin
                bad++;
                $display("FAIL cyc_mask%0d got %b want %b", i, mask, lz(ed[i]));
            end
            repeat (4) step();
        end
    endtask

    task automatic test_timeout();
        repeat (3) pulse_mode();
        repeat (9999) step();
        total++;
        if (mode !== 2'b11) begin
            bad++;
            $display("FAIL tmo_9999 got %b want 11", mode);
        end
        step();
        total++;
        if (mode !== 2'b00) begin
            bad++;
            $display("FAIL tmo_10000 got %b want 00", mode);
        end
        repeat (3) pulse_mode();
        repeat (9000) step();
        bact = 1'b1;
        step();
        bact = 1'b0;
        repeat (9999) step();
        total++;
        if (mode !== 2'b11) begin
            bad++;
            $display("FAIL act_9999 got %b want 11", mode);
        end
        step();
        total++;
        if (mode !== 2'b00) begin
            bad++;
            $display("FAIL act_10000 got %b want 00", mode);
        end
        repeat (2) pulse_mode();
        repeat (9999) step();
        pulse_mode();
        total++;
        if (mode !== 2'b11) begin
            bad++;
            $display("FAIL tmo_modewin got %b want 11", mode);
        end
        step();
        total++;
        if (mode !== 2'b11) begin
            bad++;
            $display("FAIL tmo_cleared got %b want 11", mode);
        end
    endtask

    task automatic test_blink();
        logic [3:0] e;
        repeat (3) pulse_mode();
        for (int k = 1; k <= 875; k++) begin
            step();
            if (k == 249 || k == 250 || k == 499 || k == 500 || k == 750) begin
                e = (((k / 250) % 2) == 1) ? 4'b1100 : 4'b0000;
                e = e | lz(alm);
                total++;
                if (mask !== e) begin
                    bad++;
                    $display("FAIL hr_blink%0d got %b want %b", k, mask, e);
                end
            end
        end
        bact = 1'b1;
        step();
        bact = 1'b0;
        total++;
        if (mask !== lz(alm)) begin
            bad++;
            $display("FAIL hr_act got %b want %b", mask, lz(alm));
        end
        pulse_mode();
        repeat (249) step();
        total++;
        if (mask !== lz(alm)) begin
            bad++;
            $display("FAIL min_249 got %b want %b", mask, lz(alm));
        end
        step();
        total++;
        if (mask !== (4'b0011 | lz(alm))) begin
            bad++;
            $display("FAIL min_250 got %b want %b", mask, 4'b0011 | lz(alm));
        end
    endtask

    task automatic test_ring();
        logic [3:0] e;
        pulse_mode();
        pulse_mode();
        ring = 1'b1;
        for (int j = 1; j <= 1000; j++) begin
            bmode = (j == 100 || j == 300);
            bact  = (j == 600);
            step();
            bmode = 1'b0;
            bact  = 1'b0;
            if (j == 1 || j == 249 || j == 250 || j == 300 || j == 500 ||
                j == 600 || j == 750 || j == 1000) begin
                e = (((j / 250) % 2) == 1) ? 4'b1111 : 4'b0000;
                total++;
                if (mask !== e || disp !== cur || mode !== 2'b01) begin
                    bad++;
                    $display("FAIL ring%0d got m=%b d=%0d s=%b want m=%b d=%0d s=01",
                             j, mask, disp, mode, e, cur);
                end
            end
        end
        ring = 1'b0;
        step();
        total++;
        if (disp !== alm || mode !== 2'b01 || mask !== lz(alm)) begin
            bad++;
            $display("FAIL ring_drop got d=%0d s=%b m=%b want d=%0d s=01 m=%b",
                     disp, mode, mask, alm, lz(alm));
        end
    endtask

    task automatic test_reset_ring();
        ring = 1'b1;
        rst  = 1'b1;
        step();
        total++;
        if (mode !== 2'b00 || disp !== 12'd0 || mask !== 4'b0000) begin
            bad++;
            $display("FAIL rst_ring got s=%b d=%0d m=%b want 00 0 0000",
                     mode, disp, mask);
        end
        rst  = 1'b0;
        ring = 1'b0;
        cur  = 12'd1000;
        step();
        total++;
        if (disp !== 12'd1000 || mode !== 2'b00) begin
            bad++;
            $display("FAIL rst_ring_rel got d=%0d s=%b want 1000 00", disp, mode);
        end
    endtask

    task automatic test_leading_zero();
        cur = 12'd545;
        step();
        total++;
        if (mask !== lz(12'd545) || disp !== 12'd545) begin
            bad++;
            $display("FAIL lz_545 got m=%b d=%0d want m=%b d=545",
                     mask, disp, lz(12'd545));
        end
        cur = 12'd600;
        step();
        total++;
        if (mask !== 4'b0000) begin
            bad++;
            $display("FAIL lz_600 got %b want 0000", mask);
        end
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_timeout();
        test_blink();
        test_ring();
        test_reset_ring();
        test_leading_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
